// File: rtl/handshake_elastic_fifo_pkg.sv
// Shared sizing helpers for the elastic FIFO.
// Pointer and count widths derive from DEPTH.
package handshake_pkg;

  localparam int MAX_FIFO_DEPTH = 64;

  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/handshake_elastic_fifo_if.sv
// Valid/ready token channel pair: ins upstream, outs downstream.
// The slave modport is the FIFO's view.
interface handshake_elastic_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/handshake_elastic_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write,
// asynchronous read. Contents are never reset.
module handshake_fifo_mem
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Elastic FIFO; ins_ready depends on registered count only.
// Optional HANDSHAKE_ELASTIC_FIFO_BYPASS_EN: zero-latency pass when empty.
module handshake_elastic_fifo
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic clk,
  input logic rst,
  handshake_elastic_fifo_if.slave bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  if (DEPTH < 2 || DEPTH > MAX_FIFO_DEPTH) begin : g_bad_depth
    $fatal(1, "handshake_elastic_fifo: DEPTH out of range");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata;
  logic full, empty, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign bus.ins_ready = !full;

`ifdef HANDSHAKE_ELASTIC_FIFO_BYPASS_EN
  logic bypass;
  assign bypass = empty & bus.ins_valid & bus.outs_ready;
  assign bus.outs_valid = empty ? bus.ins_valid : 1'b1;
  assign bus.outs = empty ? bus.ins : rdata;
  assign push = bus.ins_valid & !full & !bypass;
`else
  assign bus.outs_valid = !empty;
  assign bus.outs = empty ? '0 : rdata;
  assign push = bus.ins_valid & !full;
`endif

  assign pop = !empty & bus.outs_ready;

  always_comb begin
    wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case (1'b1)
      push & !pop: count_d = count_q + CW'(1);
      pop & !push: count_d = count_q - CW'(1);
      default:     count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Reset gates the write so a token offered during reset is dropped.
  handshake_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (push & !rst),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.ins),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

endmodule

// File: doc/handshake_elastic_fifo.md
Name: handshake_elastic_fifo

Overview:
Depth-parameterised elastic FIFO on the valid/ready dataflow handshake. It sits directly downstream of constant, operator and fork stages, absorbing backpressure bursts so producers can keep firing. Both channels use the standard `ins`/`outs` token protocol. `ins_ready` has no combinational path from `outs_ready`, which breaks the ready chain between stages.

Parameters:
- DATA_WIDTH, 32, token payload width in bits.
- DEPTH, 4, number of storage slots; legal range 2..64; need not be a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- ins  input  DATA_WIDTH  upstream token payload.
- ins_valid  input  1  upstream token present.
- ins_ready  output  1  FIFO can accept a token this cycle.
- outs  output  DATA_WIDTH  head-of-queue payload.
- outs_valid  output  1  head token present.
- outs_ready  input  1  downstream accepts the head token.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - Clears wr_ptr, rd_ptr and count to 0.
  - After reset: outs_valid=0, ins_ready=1, outs=0.
  - Storage array is not reset.
- Status signals:
  - push = ins_valid & ins_ready; pop = outs_valid & outs_ready.
  - ins_ready = (count != DEPTH). Registered-state only; no dependency on outs_ready.
  - outs_valid = (count != 0).
  - outs = mem[rd_ptr] when count != 0, else all zeros.
- Push: writes mem[wr_ptr] <= ins. wr_ptr advances; it wraps DEPTH-1 -> 0 by explicit compare, not modulo 2^n.
- Pop: rd_ptr advances with the same wrap rule.
- Count update: count +1 on push only, -1 on pop only, unchanged on both or neither. Count width is clog2(DEPTH+1).
- Latency: a token written in cycle N is visible on outs in cycle N+1 at the earliest.
- Throughput: one token per cycle in steady state.
- Full (count==DEPTH):
  - ins_ready=0, so no push even if outs_ready=1 in the same cycle.
  - A pop that cycle frees a slot; ins_ready=1 in the next cycle.
- Empty (count==0):
  - outs_valid=0, no pop.
  - A push makes count=1 and outs_valid=1 in the next cycle.
- Simultaneous push and pop with 0<count<DEPTH: both pointers advance, count holds. Data ordering is strict FIFO.
- Payload stability: outs holds stable while outs_valid=1 and outs_ready=0.
- Reset mid-operation: all queued tokens are discarded. A token presented during the reset cycle is not captured.
- Invalid parameters: DEPTH<2 is a fatal elaboration error.

Optional Feature:
- Macro: HANDSHAKE_ELASTIC_FIFO_BYPASS_EN.
- Defined:
  - When count==0, outs=ins and outs_valid=ins_valid combinationally; ins_ready stays 1.
  - If ins_valid & outs_ready while empty, the token passes straight through with no write and no pointer or count change.
  - If ins_valid & !outs_ready while empty, the token is written normally.
  - Latency is 0 cycles when empty.
- Undefined: behaviour exactly as above, minimum latency 1 cycle, and no combinational ins->outs path.

Decomposition:
- Package handshake_pkg holds:
  - function ptr_width(depth) = max(1, clog2(depth));
  - function cnt_width(depth) = clog2(depth+1);
  - localparam MAX_FIFO_DEPTH = 64.
- Sub-module handshake_fifo_mem:
  - DEPTH x DATA_WIDTH storage array;
  - synchronous write port (we, waddr, wdata);
  - asynchronous read port (raddr, rdata).
- Top level holds the pointers, count, handshake logic and bypass mux.

Test Plan:
- Reset then idle (DATA_WIDTH=28, DEPTH=3): hold rst=1 for 2 cycles -> outs_valid=0, ins_ready=1, outs=28'h0 on every cycle after reset deassert.
- Single token: push 28'h4AA001B with outs_ready=1 -> outs_valid=1 with outs=28'h4AA001B exactly one cycle later (zero cycles if BYPASS_EN), then outs_valid=0.
- Fill to full: outs_ready=0, push 28'h1, 28'h2, 28'h3 -> ins_ready=0 after the third push; a 4th token 28'h4 held valid is not accepted; outs stays 28'h1.
- Full plus pop: from full, raise outs_ready=1 for one cycle -> 28'h1 consumed, ins_ready=1 next cycle, then 28'h4 is accepted; drain order is 2,3,4.
- Wrap-around streaming: 10 tokens 0..9 with continuous ins_valid=1 and outs_ready=1 -> output sequence 0..9 in order, one per cycle after the first, and count never exceeds 1.
- Reset mid-operation: with 2 tokens queued, assert rst for 1 cycle -> outs_valid=0 and ins_ready=1 next cycle; the old tokens never appear on outs.
